// File: rtl/id_ex_pkg.sv
// Shared constants and helpers for the id/ex pipeline register: bus widths,
// NOP encodings, stall-vector indices and the per-edge action decode.
package id_ex_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_W       = 32;
  localparam int ALUOP_W     = 8;
  localparam int ALUSEL_W    = 3;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_W     = 6;

  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;

  localparam logic [ALUOP_W-1:0]     EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0]     EXE_OR_OP     = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0]     EXE_ORI_OP    = 8'b0101_1010;
  localparam logic [ALUSEL_W-1:0]    EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0]    EXE_RES_LOGIC = 3'b001;
  localparam logic [REG_W-1:0]       ZERO_WORD     = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic                   WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  // Flush beats everything; an ex stall holds even if id is (illegally) not stalled.
  function automatic action_e decode_action(input logic flush,
                                            input logic [STALL_W-1:0] stall);
    if (flush)                 return ACT_FLUSH;
    else if (stall[STALL_EX])  return ACT_HOLD;
    else if (stall[STALL_ID])  return ACT_BUBBLE;
    else                       return ACT_CAPTURE;
  endfunction

endpackage

// File: rtl/id_ex_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear overrides increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/id_ex.sv
// id -> ex pipeline register with stall/flush handling, bubble insertion
// and two saturating performance counters (bubbles, hold cycles).
module id_ex
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic                   cnt_clr,
  input  logic [INST_ADDR_W-1:0] id_pc,
  input  logic [ALUOP_W-1:0]     id_aluop,
  input  logic [ALUSEL_W-1:0]    id_alusel,
  input  logic [REG_W-1:0]       id_reg1,
  input  logic [REG_W-1:0]       id_reg2,
  input  logic [REG_ADDR_W-1:0]  id_wd,
  input  logic                   id_wreg,
  output logic [INST_ADDR_W-1:0] ex_pc,
  output logic [ALUOP_W-1:0]     ex_aluop,
  output logic [ALUSEL_W-1:0]    ex_alusel,
  output logic [REG_W-1:0]       ex_reg1,
  output logic [REG_W-1:0]       ex_reg2,
  output logic [REG_ADDR_W-1:0]  ex_wd,
  output logic                   ex_wreg,
  output logic                   ex_valid,
  output logic [CNT_W-1:0]       bubble_cnt_o,
  output logic [CNT_W-1:0]       hold_cnt_o
);

  action_e act;
  logic    bubble_en;
  logic    hold_en;
  logic    unused_stall_bits;

  // Only the id and ex bits of the ctrl vector matter to this stage.
  assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

  always_comb begin
    act       = decode_action(flush, stall);
    bubble_en = (act == ACT_BUBBLE);
    hold_en   = (act == ACT_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc     <= ZERO_WORD;
      ex_aluop  <= EXE_NOP_OP;
      ex_alusel <= EXE_RES_NOP;
      ex_reg1   <= ZERO_WORD;
      ex_reg2   <= ZERO_WORD;
      ex_wd     <= NOP_REG_ADDR;
      ex_wreg   <= WRITE_DISABLE;
      ex_valid  <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          ex_pc     <= ZERO_WORD;
          ex_aluop  <= EXE_NOP_OP;
          ex_alusel <= EXE_RES_NOP;
          ex_reg1   <= ZERO_WORD;
          ex_reg2   <= ZERO_WORD;
          ex_wd     <= NOP_REG_ADDR;
          ex_wreg   <= WRITE_DISABLE;
          ex_valid  <= 1'b0;
        end
        ACT_HOLD: begin
        end
        default: begin
          ex_pc     <= id_pc;
          ex_aluop  <= id_aluop;
          ex_alusel <= id_alusel;
          ex_reg1   <= id_reg1;
          ex_reg2   <= id_reg2;
          ex_wd     <= id_wd;
          ex_wreg   <= id_wreg;
          ex_valid  <= 1'b1;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .en  (bubble_en),
    .clr (cnt_clr),
    .cnt (bubble_cnt_o)
  );

  sat_cnt #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .clr (cnt_clr),
    .cnt (hold_cnt_o)
  );

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cnt_clr;
  logic [31:0] id_pc;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic [4:0]  id_wd;
  logic        id_wreg;

  logic [31:0] ex_pc;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic        ex_valid;
  logic [15:0] bubble_cnt_o;
  logic [15:0] hold_cnt_o;

  logic [31:0] n_unused_pc;
  logic [7:0]  n_unused_aluop;
  logic [2:0]  n_unused_alusel;
  logic [31:0] n_unused_reg1;
  logic [31:0] n_unused_reg2;
  logic [4:0]  n_unused_wd;
  logic        n_unused_wreg;
  logic        n_unused_valid;
  logic [1:0]  n_bubble_cnt;
  logic [1:0]  n_hold_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        valid;
  } ex_t;

  localparam ex_t BUBBLE = '{pc: 32'd0, aluop: 8'h00, alusel: 3'd0, reg1: 32'd0,
                             reg2: 32'd0, wd: 5'd0, wreg: 1'b0, valid: 1'b0};
  localparam int WIDE_MAX   = 65535;
  localparam int NARROW_MAX = 3;

  ex_t m_ex;
  int  m_bub, m_hold, m_nbub, m_nhold;

  always #5 clk = ~clk;

  id_ex dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_pc(id_pc), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_valid(ex_valid), .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
  );

  id_ex #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_pc(id_pc), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_pc(n_unused_pc), .ex_aluop(n_unused_aluop), .ex_alusel(n_unused_alusel),
    .ex_reg1(n_unused_reg1), .ex_reg2(n_unused_reg2), .ex_wd(n_unused_wd),
    .ex_wreg(n_unused_wreg), .ex_valid(n_unused_valid),
    .bubble_cnt_o(n_bubble_cnt), .hold_cnt_o(n_hold_cnt)
  );

  function automatic int satInc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  // Reference behaviour: flush > hold > bubble > capture; clear overrides counting.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ex <= BUBBLE;
      m_bub <= 0; m_hold <= 0; m_nbub <= 0; m_nhold <= 0;
    end else begin
      assert (!(stall[3] && !stall[2])) else $error("[TB] ctrl contract broken: stall=%b", stall);
      if (flush) begin
        m_ex <= BUBBLE;
      end else if (stall[3]) begin
        m_hold  <= satInc(m_hold, WIDE_MAX);
        m_nhold <= satInc(m_nhold, NARROW_MAX);
      end else if (stall[2]) begin
        m_ex   <= BUBBLE;
        m_bub  <= satInc(m_bub, WIDE_MAX);
        m_nbub <= satInc(m_nbub, NARROW_MAX);
      end else begin
        m_ex <= '{pc: id_pc, aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                  reg2: id_reg2, wd: id_wd, wreg: id_wreg, valid: 1'b1};
      end
      if (cnt_clr) begin
        m_bub <= 0; m_hold <= 0; m_nbub <= 0; m_nhold <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model.pc",     ex_pc,               m_ex.pc);
    checkOutput("model.aluop",  32'(ex_aluop),       32'(m_ex.aluop));
    checkOutput("model.alusel", 32'(ex_alusel),      32'(m_ex.alusel));
    checkOutput("model.reg1",   ex_reg1,             m_ex.reg1);
    checkOutput("model.reg2",   ex_reg2,             m_ex.reg2);
    checkOutput("model.wd",     32'(ex_wd),          32'(m_ex.wd));
    checkOutput("model.wreg",   32'(ex_wreg),        32'(m_ex.wreg));
    checkOutput("model.valid",  32'(ex_valid),       32'(m_ex.valid));
    checkOutput("model.bub",    32'(bubble_cnt_o),   32'(m_bub));
    checkOutput("model.hold",   32'(hold_cnt_o),     32'(m_hold));
    checkOutput("model.nbub",   32'(n_bubble_cnt),   32'(m_nbub));
    checkOutput("model.nhold",  32'(n_hold_cnt),     32'(m_nhold));
  endtask

  task automatic waitCycle();
    @(negedge clk);
    compareModel();
  endtask

  task automatic applyStimulus(input logic [5:0] s, input logic f, input logic c,
                               input logic [31:0] pc, input logic [7:0] op,
                               input logic [2:0] sel, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [4:0] wd,
                               input logic wr);
    stall = s; flush = f; cnt_clr = c;
    id_pc = pc; id_aluop = op; id_alusel = sel;
    id_reg1 = r1; id_reg2 = r2; id_wd = wd; id_wreg = wr;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(6'b0, 1'b0, 1'b0, 32'h0, 8'h0, 3'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset.aluop", 32'(ex_aluop), 32'h00);
    checkOutput("reset.valid", 32'(ex_valid), 32'h0);
    checkOutput("reset.bub",   32'(bubble_cnt_o), 32'h0);
    rst = 1'b0;

    // Mid-cycle asynchronous reset while an OR is in ex
    applyStimulus(6'b0, 1'b0, 1'b0, 32'h100, 8'b0010_0101, 3'b001,
                  32'h1234_5678, 32'h0F0F_0F0F, 5'd7, 1'b1);
    waitCycle();
    checkOutput("or.aluop", 32'(ex_aluop), 32'h25);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.aluop", 32'(ex_aluop), 32'h00);
    checkOutput("midrst.reg1",  ex_reg1, 32'h0);
    checkOutput("midrst.wreg",  32'(ex_wreg), 32'h0);
    checkOutput("midrst.valid", 32'(ex_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ori capture, one cycle latency
    applyStimulus(6'b0, 1'b0, 1'b0, 32'h100, 8'b0101_1010, 3'b001,
                  32'h0000_1100, 32'h0000_0020, 5'd3, 1'b1);
    waitCycle();
    checkOutput("ori.reg1",  ex_reg1, 32'h0000_1100);
    checkOutput("ori.reg2",  ex_reg2, 32'h0000_0020);
    checkOutput("ori.wd",    32'(ex_wd), 32'd3);
    checkOutput("ori.valid", 32'(ex_valid), 32'd1);

    // Two stall bubbles, then the next instruction is captured
    applyStimulus(6'b000111, 1'b0, 1'b0, 32'h104, 8'h11, 3'd2,
                  32'hAAAA_0001, 32'hBBBB_0002, 5'd9, 1'b1);
    waitCycle();
    checkOutput("bub1.valid", 32'(ex_valid), 32'd0);
    waitCycle();
    checkOutput("bub2.aluop", 32'(ex_aluop), 32'h00);
    checkOutput("bub2.cnt",   32'(bubble_cnt_o), 32'd2);
    stall = 6'b0;
    waitCycle();
    checkOutput("after_bub.pc",    ex_pc, 32'h104);
    checkOutput("after_bub.valid", 32'(ex_valid), 32'd1);

    // Three hold cycles keep the instruction at 0x104
    applyStimulus(6'b001111, 1'b0, 1'b0, 32'h108, 8'h22, 3'd3,
                  32'hCCCC_0003, 32'hDDDD_0004, 5'd10, 1'b0);
    repeat (3) waitCycle();
    checkOutput("hold.pc",   ex_pc, 32'h104);
    checkOutput("hold.reg1", ex_reg1, 32'hAAAA_0001);
    checkOutput("hold.cnt",  32'(hold_cnt_o), 32'd3);

    // Flush during a hold drops the held instruction without counting
    flush = 1'b1;
    waitCycle();
    checkOutput("flush.valid", 32'(ex_valid), 32'd0);
    checkOutput("flush.pc",    ex_pc, 32'h0);
    checkOutput("flush.hold",  32'(hold_cnt_o), 32'd3);
    flush = 1'b0;

    // Narrow counter saturates; clear wins over a same-cycle increment
    stall = 6'b000111;
    repeat (5) waitCycle();
    checkOutput("sat.narrow", 32'(n_bubble_cnt), 32'd3);
    checkOutput("sat.wide",   32'(bubble_cnt_o), 32'd7);
    cnt_clr = 1'b1;
    waitCycle();
    checkOutput("clr.narrow", 32'(n_bubble_cnt), 32'd0);
    checkOutput("clr.wide",   32'(bubble_cnt_o), 32'd0);
    cnt_clr = 1'b0;

    // Randomized traffic against the model, ctrl contract respected
    for (int i = 0; i < 500; i++) begin
      logic [5:0] s;
      case ($urandom_range(0, 7))
        0:       s = 6'b000111;
        1:       s = 6'b001111;
        2:       s = 6'b011111;
        3:       s = 6'b000011;
        default: s = 6'b000000;
      endcase
      applyStimulus(s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    $urandom, 8'($urandom), 3'($urandom), $urandom, $urandom,
                    5'($urandom), 1'($urandom));
      waitCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
